// File: rtl/oam_dma_arbiter_pkg.sv
// Shared bus operation encoding for the CPU/MMU port.
package oam_dma_arbiter_pkg;

    typedef enum logic [1:0] {
        BUS_IDLE  = 2'd0,
        BUS_READ  = 2'd1,
        BUS_WRITE = 2'd2
    } bus_op_t;

endpackage

// File: rtl/oam_dma_arbiter_if.sv
// Byte-wide memory bus: requester is master, responder is slave.
interface oam_dma_arbiter_if;
    import oam_dma_arbiter_pkg::*;

    bus_op_t     bus_op;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;

    modport master (output bus_op, output addr, output wdata, input rdata);
    modport slave  (input bus_op, input addr, input wdata, output rdata);

endinterface

// File: rtl/oam_dma_arbiter.sv
// Shares the single MMU port between the CPU and the OAM DMA engine.
module oam_dma_arbiter
    import oam_dma_arbiter_pkg::*;
#(
    parameter logic [15:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [15:0] OAM_BASE     = 16'hFE00,
    parameter int unsigned DMA_LEN      = 160,
    parameter logic [15:0] HRAM_LO      = 16'hFF80,
    parameter logic [15:0] HRAM_HI      = 16'hFFFE
) (
    input  logic                    clk,
    input  logic                    reset,
    oam_dma_arbiter_if.slave        cpu,
    oam_dma_arbiter_if.master       mmu,
    output logic                    dma_active
);

    localparam int unsigned IDX_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_WR   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        RSEL_PASS = 2'd0,
        RSEL_REG  = 2'd1,
        RSEL_BLK  = 2'd2
    } rsel_t;

    state_t             state_q, state_d;
    rsel_t              rsel_q, rsel_d;
    logic [7:0]         src_q, src_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic               first_wr_q, first_wr_d;
    logic [7:0]         dma_buf_q, dma_buf_d;

    logic               hram_hit;
    logic               reg_hit;
    logic               reg_wr;
    logic               blocked;
    logic [7:0]         src_eff;
    logic [7:0]         wr_data;

    // CPU access classification and DMA datapath helpers
    assign dma_active = (state_q != ST_IDLE);
    assign hram_hit   = (cpu.bus_op != BUS_IDLE) && (cpu.addr >= HRAM_LO) && (cpu.addr <= HRAM_HI);
    assign reg_hit    = (cpu.addr == DMA_REG_ADDR);
    assign reg_wr     = (cpu.bus_op == BUS_WRITE) && reg_hit;
    assign blocked    = dma_active && !hram_hit && !reg_hit;
    // Echo RAM (E000-FDFF) mirrors C000-DDFF
    assign src_eff    = (src_q >= 8'hE0) ? 8'(src_q - 8'h20) : src_q;
    // Byte read in RD arrives on mmu.rdata only in the first WR cycle
    assign wr_data    = first_wr_q ? mmu.rdata : dma_buf_q;

    // Next-state, port ownership and MMU drive
    always_comb begin
        state_d    = state_q;
        rsel_d     = rsel_q;
        src_d      = src_q;
        idx_d      = idx_q;
        first_wr_d = first_wr_q;
        dma_buf_d  = dma_buf_q;
        mmu.bus_op = BUS_IDLE;
        mmu.addr   = 16'h0000;
        mmu.wdata  = 8'h00;

        unique case (state_q)
            ST_IDLE: begin
                if (!reg_hit) begin
                    mmu.bus_op = cpu.bus_op;
                    mmu.addr   = cpu.addr;
                    mmu.wdata  = cpu.wdata;
                end
            end
            ST_RD: begin
                if (hram_hit) begin
                    mmu.bus_op = cpu.bus_op;
                    mmu.addr   = cpu.addr;
                    mmu.wdata  = cpu.wdata;
                end else begin
                    mmu.bus_op = BUS_READ;
                    mmu.addr   = {src_eff, idx_q};
                    state_d    = ST_WR;
                    first_wr_d = 1'b1;
                end
            end
            ST_WR: begin
                if (first_wr_q) begin
                    dma_buf_d  = mmu.rdata;
                    first_wr_d = 1'b0;
                end
                if (hram_hit) begin
                    mmu.bus_op = cpu.bus_op;
                    mmu.addr   = cpu.addr;
                    mmu.wdata  = cpu.wdata;
                end else begin
                    mmu.bus_op = BUS_WRITE;
                    mmu.addr   = 16'(OAM_BASE + {8'h00, idx_q});
                    mmu.wdata  = wr_data;
                    if (idx_q == IDX_W'(DMA_LEN - 1)) begin
                        state_d = ST_IDLE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = ST_RD;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // Register write starts (or restarts) a transfer and never reaches the MMU
        if (reg_wr) begin
            src_d      = cpu.wdata;
            idx_d      = '0;
            state_d    = ST_RD;
            mmu.bus_op = BUS_IDLE;
            mmu.addr   = 16'h0000;
            mmu.wdata  = 8'h00;
        end

        if (cpu.bus_op == BUS_READ) begin
            if (reg_hit)      rsel_d = RSEL_REG;
            else if (blocked) rsel_d = RSEL_BLK;
            else              rsel_d = RSEL_PASS;
        end
    end

    // CPU read return mux, one cycle after the request
    always_comb begin
        cpu.rdata = mmu.rdata;
        unique case (rsel_q)
            RSEL_REG: cpu.rdata = src_q;
            RSEL_BLK: cpu.rdata = 8'hFF;
            default:  cpu.rdata = mmu.rdata;
        endcase
    end

    // State registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= ST_IDLE;
            rsel_q     <= RSEL_PASS;
            src_q      <= 8'h00;
            idx_q      <= '0;
            first_wr_q <= 1'b0;
            dma_buf_q  <= 8'h00;
        end else begin
            state_q    <= state_d;
            rsel_q     <= rsel_d;
            src_q      <= src_d;
            idx_q      <= idx_d;
            first_wr_q <= first_wr_d;
            dma_buf_q  <= dma_buf_d;
        end
    end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
// Bench for oam_dma_arbiter: table vectors, transfer sequences, read scoreboard.
module tb_oam_dma_arbiter;
    import oam_dma_arbiter_pkg::*;

    logic clk;
    logic reset;
    logic dma_active;

    oam_dma_arbiter_if cpu_if ();
    oam_dma_arbiter_if mmu_if ();

    oam_dma_arbiter dut (
        .clk        (clk),
        .reset      (reset),
        .cpu        (cpu_if),
        .mmu        (mmu_if),
        .dma_active (dma_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Memory model behind the MMU port: registered read data, write on the edge
    logic [7:0] mem [0:65535];
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            mmu_if.rdata <= 8'h00;
        end else begin
            if (mmu_if.bus_op == BUS_READ)  mmu_if.rdata <= mem[mmu_if.addr];
            if (mmu_if.bus_op == BUS_WRITE) mem[mmu_if.addr] <= mmu_if.wdata;
        end
    end

    typedef struct {
        string      nm;
        logic [7:0] exp;
    } sb_t;
    sb_t sb [$];

    typedef struct {
        bus_op_t     op;
        logic [15:0] addr;
        logic [7:0]  wdata;
        logic [7:0]  rexp;
        bus_op_t     mexp;
        string       nm;
    } vec_t;

    int total = 0;
    int bad   = 0;
    int act_cnt = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // One bus cycle: drive, optionally check MMU op, then compare any pending read
    task automatic cyc(input bus_op_t op, input logic [15:0] a, input logic [7:0] d,
                       input bit mchk, input bus_op_t mexp, input logic [7:0] rexp,
                       input string nm);
        sb_t e;
        cpu_if.bus_op = op;
        cpu_if.addr   = a;
        cpu_if.wdata  = d;
        if (op == BUS_READ) sb.push_back('{nm, rexp});
        if (dma_active) act_cnt++;
        #1;
        if (mchk) check({nm, "_mmuop"}, 32'(mmu_if.bus_op), 32'(mexp));
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check(e.nm, 32'(cpu_if.rdata), 32'(e.exp));
        end
        cpu_if.bus_op = BUS_IDLE;
    endtask

    task automatic idle();
        cyc(BUS_IDLE, 16'h0000, 8'h00, 1'b0, BUS_IDLE, 8'h00, "idle");
    endtask

    task automatic wr(input logic [15:0] a, input logic [7:0] d);
        cyc(BUS_WRITE, a, d, 1'b0, BUS_IDLE, 8'h00, "wr");
    endtask

    task automatic rd(input logic [15:0] a, input logic [7:0] exp, input string nm);
        cyc(BUS_READ, a, 8'h00, 1'b0, BUS_IDLE, exp, nm);
    endtask

    // Fill 160 bytes at base with i^k through the DUT while idle
    task automatic fill(input logic [15:0] base, input logic [7:0] k);
        for (int i = 0; i < 160; i++) wr(16'(base + 16'(i)), 8'(i) ^ k);
    endtask

    // Run idle cycles until the transfer ends, bounded
    task automatic wait_done(input string nm);
        for (int k = 0; k < 1000 && dma_active; k++) idle();
        check({nm, "_timeout"}, 32'(dma_active), 32'd0);
    endtask

    function automatic int oam_errs(input logic [7:0] k);
        int n = 0;
        for (int i = 0; i < 160; i++)
            if (mem[16'(16'hFE00 + 16'(i))] !== (8'(i) ^ k)) n++;
        return n;
    endfunction

    vec_t vecs [8];

    initial begin
        vecs[0] = '{BUS_WRITE, 16'hC123, 8'h12, 8'h00, BUS_WRITE, "pass_wr"};
        vecs[1] = '{BUS_READ,  16'hC123, 8'h00, 8'h12, BUS_READ,  "pass_rd"};
        vecs[2] = '{BUS_WRITE, 16'hFF80, 8'h42, 8'h00, BUS_WRITE, "hram_wr"};
        vecs[3] = '{BUS_READ,  16'hFF80, 8'h00, 8'h42, BUS_READ,  "hram_rd"};
        vecs[4] = '{BUS_READ,  16'hFF46, 8'h00, 8'h00, BUS_IDLE,  "reg_rd_reset"};
        vecs[5] = '{BUS_WRITE, 16'hFFFF, 8'h5C, 8'h00, BUS_WRITE, "ie_wr"};
        vecs[6] = '{BUS_READ,  16'hFFFF, 8'h00, 8'h5C, BUS_READ,  "ie_rd"};
        vecs[7] = '{BUS_IDLE,  16'h0000, 8'h00, 8'h00, BUS_IDLE,  "idle_op"};

        cpu_if.bus_op = BUS_IDLE;
        cpu_if.addr   = 16'h0000;
        cpu_if.wdata  = 8'h00;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_dma_active", 32'(dma_active), 32'd0);
        check("rst_cpu_rdata", 32'(cpu_if.rdata), 32'h00);
        check("rst_mmu_op", 32'(mmu_if.bus_op), 32'(BUS_IDLE));
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Idle passthrough vectors
        for (int i = 0; i < 8; i++)
            cyc(vecs[i].op, vecs[i].addr, vecs[i].wdata, 1'b1, vecs[i].mexp, vecs[i].rexp, vecs[i].nm);

        fill(16'hC000, 8'h5A);
        fill(16'hD000, 8'hA5);

        // Basic copy
        fill(16'hFE00, 8'hEE);
        cyc(BUS_WRITE, 16'hFF46, 8'hC0, 1'b1, BUS_IDLE, 8'h00, "dma_start");
        act_cnt = 0;
        wait_done("basic");
        check("basic_cycles", 32'(act_cnt), 32'd320);
        check("basic_oam", 32'(oam_errs(8'h5A)), 32'd0);
        rd(16'hFF46, 8'hC0, "reg_rd_src");
        idle();

        // Blocked CPU accesses during a transfer
        fill(16'hFE00, 8'hEE);
        wr(16'hFF46, 8'hC0);
        act_cnt = 0;
        rd(16'hC000, 8'hFF, "blk_rd");
        wr(16'hC001, 8'h11);
        rd(16'hFF80, 8'h42, "blk_hram_rd");
        wait_done("blk");
        check("blk_cycles", 32'(act_cnt), 32'd321);
        check("blk_c001", 32'(mem[16'hC001]), 32'h5B);
        check("blk_oam", 32'(oam_errs(8'h5A)), 32'd0);

        // HRAM stall of 10 cycles starting on a first WR cycle
        fill(16'hFE00, 8'hEE);
        wr(16'hFF46, 8'hC0);
        act_cnt = 0;
        repeat (21) idle();
        for (int i = 0; i < 10; i++) rd(16'hFF80, 8'h42, "stall_hram_rd");
        wait_done("stall");
        check("stall_cycles", 32'(act_cnt), 32'd330);
        check("stall_oam", 32'(oam_errs(8'h5A)), 32'd0);

        // Echo source page
        fill(16'hFE00, 8'hEE);
        wr(16'hFF46, 8'hE0);
        act_cnt = 0;
        wait_done("echo");
        check("echo_oam", 32'(oam_errs(8'h5A)), 32'd0);

        // Restart at idx 50 with a new page
        fill(16'hFE00, 8'hEE);
        wr(16'hFF46, 8'hC0);
        act_cnt = 0;
        repeat (100) idle();
        wr(16'hFF46, 8'hD0);
        check("restart_active_cnt", 32'(act_cnt), 32'd101);
        check("restart_active_now", 32'(dma_active), 32'd1);
        act_cnt = 0;
        wait_done("restart");
        check("restart_cycles", 32'(act_cnt), 32'd320);
        check("restart_oam", 32'(oam_errs(8'hA5)), 32'd0);

        // Restart coinciding with the final write suppresses that write
        fill(16'hFE00, 8'hEE);
        wr(16'hFF46, 8'hC0);
        act_cnt = 0;
        repeat (319) idle();
        wr(16'hFF46, 8'hD0);
        check("final_active_cnt", 32'(act_cnt), 32'd320);
        check("final_byte_kept", 32'(mem[16'hFE9F]), 32'h71);
        check("final_active_now", 32'(dma_active), 32'd1);
        act_cnt = 0;
        wait_done("final");
        check("final_cycles", 32'(act_cnt), 32'd320);
        check("final_oam", 32'(oam_errs(8'hA5)), 32'd0);

        // Reset in the middle of a transfer
        wr(16'hFF46, 8'hC0);
        repeat (160) idle();
        check("mid_active_before", 32'(dma_active), 32'd1);
        reset = 1'b0;
        #1;
        check("mid_rst_active", 32'(dma_active), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
        cyc(BUS_WRITE, 16'hC000, 8'h77, 1'b1, BUS_WRITE, 8'h00, "mid_wr");
        cyc(BUS_READ, 16'hC000, 8'h00, 1'b1, BUS_READ, 8'h77, "mid_rd");
        idle();
        check("mid_active_after", 32'(dma_active), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/oam_dma_arbiter.md
Name: oam_dma_arbiter

Overview:
- Owns the single MMU port and shares it between the CPU bus and an internal OAM DMA engine.
- A CPU write to FF46 latches a source page and copies 160 bytes from {src,00}..{src,9F} to FE00..FE9F.
- During the copy, the CPU is restricted to HRAM (FF80–FFFE) and FF46; every other CPU access is blocked.
- Sits between the CPU bus and MMU in the top level; the MMU is unchanged.

Parameters:
- DMA_REG_ADDR, 16'hFF46, address of the DMA source register.
- OAM_BASE, 16'hFE00, destination base address.
- DMA_LEN, 160, bytes per transfer.
- HRAM_LO, 16'hFF80, lowest CPU-accessible address during DMA.
- HRAM_HI, 16'hFFFE, highest CPU-accessible address during DMA.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset (asserted when 0).
- cpu_bus_op  in  bus_op_t  CPU request: BUS_IDLE/BUS_READ/BUS_WRITE.
- cpu_addr  in  16  CPU address.
- cpu_data_in  in  8  CPU write data.
- cpu_data_out  out  8  CPU read data, valid the cycle after the BUS_READ.
- mmu_bus_op  out  bus_op_t  to MMU mmu_bus_op.
- mmu_addr  out  16  to MMU addr.
- mmu_wdata  out  8  to MMU data_in.
- mmu_rdata  in  8  from MMU data_out, valid the cycle after a BUS_READ.
- dma_active  out  1  high while a transfer is in progress.

Behaviour:
- **State and reset.**
  - States: IDLE, RD, WR.
  - On reset assertion (async): state=IDLE, src=8'h00, idx=0, first_wr=0, rsel=PASS.
  - Resulting outputs: dma_active=0, cpu_data_out=mmu_rdata.
  - Reset mid-transfer aborts immediately. There is no resume.
- **DMA register.** Applies in any state.
  - A CPU BUS_WRITE with cpu_addr==DMA_REG_ADDR sets src<=cpu_data_in, idx<=0 and state<=RD.
  - This write is not forwarded to the MMU (mmu_bus_op=BUS_IDLE that cycle).
  - A write during an active transfer restarts the transfer from idx 0 with the new src.
- **Effective source high byte.** src_eff = (src>=8'hE0) ? src-8'h20 : src (echo mapping).
- **CPU access classification.**
  - hram_hit = cpu_bus_op!=BUS_IDLE && HRAM_LO<=cpu_addr<=HRAM_HI.
  - reg_hit = cpu_addr==DMA_REG_ADDR.
- **IDLE state.**
  - CPU drives the MMU directly: mmu_bus_op=cpu_bus_op, mmu_addr=cpu_addr, mmu_wdata=cpu_data_in.
  - Exception: reg_hit.
- **RD state.**
  - If hram_hit: the CPU owns the port this cycle and the DMA stalls (no state change).
  - Else: mmu_bus_op=BUS_READ, mmu_addr={src_eff, idx[7:0]}; next state=WR, first_wr<=1.
- **WR state.**
  - Write data = first_wr ? mmu_rdata : dma_buf.
  - In the first WR cycle, dma_buf<=mmu_rdata and first_wr<=0, regardless of stall.
  - If hram_hit: the CPU owns the port and the DMA stalls in WR.
  - Else: mmu_bus_op=BUS_WRITE, mmu_addr=OAM_BASE+idx, mmu_wdata=write data.
    - If idx==DMA_LEN-1: state=IDLE.
    - Otherwise: idx<=idx+1, state=RD.
- **Timing.** An unstalled transfer takes exactly 2*DMA_LEN=320 cycles. dma_active = state!=IDLE, combinational from state.
- **Blocked CPU accesses** (dma_active, not hram_hit, not reg_hit):
  - Reads return 8'hFF the next cycle.
  - Writes are dropped.
  - The MMU never sees them.
- **Read return (rsel, registered each cycle on any CPU BUS_READ).**
  - rsel=REG if reg_hit → cpu_data_out=src.
  - rsel=BLK if blocked → cpu_data_out=8'hFF.
  - Otherwise rsel=PASS → cpu_data_out=mmu_rdata.
  - rsel holds its value when cpu_bus_op is not BUS_READ.
- **Simultaneous events.**
  - A CPU write to FF46 coinciding with the final WR write: the restart wins, and the final byte is not written.
- All MMU-side outputs are combinational; the MMU registers them.

Test Plan:
- **Basic copy.**
  - Stimulus: preload C000..C09F with i^8'h5A, then CPU write FF46=8'hC0.
  - Required: dma_active high for exactly 320 cycles; FE00..FE9F==i^8'h5A; CPU read of FF46 returns 8'hC0.
- **Blocking.**
  - Stimulus: during DMA, CPU reads C000, writes C001=8'h11, reads FF80 after priming it with 8'h42.
  - Required: reads return 8'hFF and 8'h42; C001 unchanged; DMA still completes with correct data.
- **HRAM stall.**
  - Stimulus: issue CPU HRAM reads on 10 consecutive cycles mid-transfer, some landing on the first WR cycle.
  - Required: transfer takes 330 cycles; all 160 OAM bytes correct (dma_buf path exercised).
- **Echo source.**
  - Stimulus: write FF46=8'hE0 with C000.. preloaded.
  - Required: OAM receives the C000..C09F contents.
- **Restart.**
  - Stimulus: write FF46=8'hC0; at idx 50 write FF46=8'hD0.
  - Required: FE00..FE9F end equal to D000..D09F; dma_active stays high through the restart.
- **Reset mid-transfer.**
  - Stimulus: assert reset (0) at idx 80, release, then CPU writes C000=8'h77 and reads it back.
  - Required: dma_active=0 immediately on assertion; CPU access passes through; read returns 8'h77.
